armleocpu_simple2axi_converter: RTL and testbench

Initiator-side bridge that turns a single-outstanding simple request (address, read/write, data, byte enables) into an AXI4-Lite master transaction and returns data and response. It sits between an internal requester (debug unit, boot loader, DMA-less peripheral master) and the AXI interconnect. It is the counterpart of the AXI-to-simple responder on the slave side. Exactly one transaction is in flight at a time; there are no IDs and no bursts.

---
 rtl/armleocpu_simple2axi_converter.sv | 184 ++++++++++++++++++
 tb/tb_armleocpu_simple2axi_converter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/armleocpu_simple2axi_converter.sv
// Simple single-outstanding request to AXI4-Lite master bridge.
// Optional SIMPLE2AXI_ALIGN_CHECK_EN: misaligned requests complete locally with SLVERR.
//   state      | meaning
//   IDLE       | ready for a new request
//   WRITE_REQ  | AW and W offered, each retired independently
//   WRITE_RESP | waiting for B beat
//   READ_REQ   | AR offered
//   READ_RESP  | waiting for R beat
module armleocpu_simple2axi_converter #(
  parameter int ADDR_WIDTH = 34
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid,
  output logic                  ready,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           write_data,
  input  logic [3:0]            write_byteenable,
  output logic                  done,
  output logic [1:0]            response,
  output logic [31:0]           read_data,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [ADDR_WIDTH-1:0] axi_awaddr,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  output logic [31:0]           axi_wdata,
  output logic [3:0]            axi_wstrb,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  input  logic [1:0]            axi_bresp,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  input  logic [1:0]            axi_rresp,
  input  logic [31:0]           axi_rdata
);

  typedef enum logic [2:0] {IDLE, WRITE_REQ, WRITE_RESP, READ_REQ, READ_RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  done_q, done_d;
  logic [1:0]            response_q, response_d;
  logic [31:0]           read_data_q, read_data_d;
  logic                  misaligned;
  logic                  aw_hs, w_hs;

`ifdef SIMPLE2AXI_ALIGN_CHECK_EN
  assign misaligned = (address[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign aw_hs = awvalid_q && axi_awready;
  assign w_hs  = wvalid_q && axi_wready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    done_d      = 1'b0;
    response_d  = response_q;
    read_data_d = read_data_q;
    case (state_q)
      IDLE: begin
        if (valid) begin
          addr_d    = address;
          wdata_d   = write_data;
          wstrb_d   = write_byteenable;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (misaligned) begin
            response_d = 2'b10;
            done_d     = 1'b1;
          end else if (write) begin
            state_d   = WRITE_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = READ_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      WRITE_REQ: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs))
          state_d = WRITE_RESP;
      end
      WRITE_RESP: begin
        if (axi_bvalid) begin
          response_d = axi_bresp;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      READ_REQ: begin
        if (axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = READ_RESP;
        end
      end
      READ_RESP: begin
        if (axi_rvalid) begin
          read_data_d = axi_rdata;
          response_d  = axi_rresp;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      done_q      <= 1'b0;
      response_q  <= 2'b00;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      done_q      <= done_d;
      response_q  <= response_d;
      read_data_q <= read_data_d;
    end
  end

  // Readies are gated by rst_n so nothing is accepted while reset is asserted.
  assign ready       = rst_n && (state_q == IDLE);
  assign axi_bready  = rst_n && (state_q == WRITE_RESP);
  assign axi_rready  = rst_n && (state_q == READ_RESP);
  assign axi_awvalid = awvalid_q;
  assign axi_awaddr  = addr_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_arvalid = arvalid_q;
  assign axi_araddr  = addr_q;
  assign done        = done_q;
  assign response    = response_q;
  assign read_data   = read_data_q;

endmodule

// File: tb/tb_armleocpu_simple2axi_converter.sv
// Directed bench for armleocpu_simple2axi_converter; honours SIMPLE2AXI_ALIGN_CHECK_EN.
module tb_armleocpu_simple2axi_converter;
  localparam int AW = 34;

  logic          clk = 1'b0;
  logic          rst_n, valid, ready, write, done;
  logic [AW-1:0] address, axi_awaddr, axi_araddr;
  logic [31:0]   write_data, read_data, axi_wdata, axi_rdata;
  logic [3:0]    write_byteenable, axi_wstrb;
  logic [1:0]    response, axi_bresp, axi_rresp;
  logic          axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic          axi_bvalid, axi_bready, axi_arvalid, axi_arready, axi_rvalid, axi_rready;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  armleocpu_simple2axi_converter #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .ready(ready), .write(write),
    .address(address), .write_data(write_data), .write_byteenable(write_byteenable),
    .done(done), .response(response), .read_data(read_data),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rresp(axi_rresp), .axi_rdata(axi_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic slave_idle();
    axi_awready = 0; axi_wready = 0; axi_arready = 0;
    axi_bvalid = 0; axi_rvalid = 0; axi_bresp = 0; axi_rresp = 0; axi_rdata = 0;
  endtask

  // Zero-wait slave, B/R offered continuously; records when done appears.
  task automatic xact(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                      input logic [1:0] rsp, output int done_cyc, output int done_cnt,
                      output logic ar_seen, output logic [AW-1:0] ar_a);
    @(negedge clk);
    valid = 1; write = wr; address = a; write_data = d; write_byteenable = 4'hF;
    axi_awready = 1; axi_wready = 1; axi_arready = 1; axi_bvalid = 1; axi_rvalid = 1;
    axi_bresp = rsp; axi_rresp = rsp; axi_rdata = d;
    done_cyc = 0; done_cnt = 0; ar_seen = 0; ar_a = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      valid = 0;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (axi_arvalid) begin
        ar_seen = 1;
        ar_a = axi_araddr;
      end
    end
    slave_idle();
  endtask

  initial begin
    int aw_hi, w_hi, aw_hs, b_hs, dn, bad, ar_hi, done_c, dcyc, dcnt;
    logic ars;
    logic [AW-1:0] ara;

    rst_n = 0; valid = 0; write = 0; address = '0; write_data = '0; write_byteenable = '0;
    slave_idle();
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_awvalid", axi_awvalid, 0);
    chk("rst_wvalid", axi_wvalid, 0);
    chk("rst_arvalid", axi_arvalid, 0);
    chk("rst_bready", axi_bready, 0);
    chk("rst_rready", axi_rready, 0);
    chk("rst_done", done, 0);
    chk("rst_response", response, 0);
    chk("rst_read_data", read_data, 0);
    rst_n = 1;
    #1 chk("rel_ready", ready, 1);

    // Zero-wait write
    @(negedge clk);
    valid = 1; write = 1; address = 34'h100; write_data = 32'hDEADBEEF; write_byteenable = 4'hF;
    axi_awready = 1; axi_wready = 1;
    @(negedge clk);
    chk("w1_awvalid", axi_awvalid, 1);
    chk("w1_wvalid", axi_wvalid, 1);
    chk("w1_awaddr", axi_awaddr, 34'h100);
    chk("w1_wdata", axi_wdata, 32'hDEADBEEF);
    chk("w1_wstrb", axi_wstrb, 4'hF);
    chk("w1_ready_busy", ready, 0);
    valid = 0; write = 0; address = 34'h3FC; write_data = 32'h0; write_byteenable = 4'h0;
    @(negedge clk);
    chk("w1_awvalid_drop", axi_awvalid, 0);
    chk("w1_wvalid_drop", axi_wvalid, 0);
    chk("w1_bready", axi_bready, 1);
    chk("w1_no_early_done", done, 0);
    axi_bvalid = 1; axi_bresp = 2'b00;
    @(negedge clk);
    chk("w1_done", done, 1);
    chk("w1_ready_with_done", ready, 1);
    chk("w1_response", response, 2'b00);
    slave_idle();
    @(negedge clk);
    chk("w1_done_pulse", done, 0);

    // Write with W stalled after AW; spurious B offered throughout
    valid = 1; write = 1; address = 34'h104; write_data = 32'h0A0B0C0D; write_byteenable = 4'h3;
    aw_hi = 0; w_hi = 0; aw_hs = 0; b_hs = 0; dn = 0; bad = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      valid = 0;
      axi_awready = 1; axi_wready = (c == 4); axi_bvalid = 1; axi_bresp = 2'b10;
      aw_hi += int'(axi_awvalid);
      w_hi  += int'(axi_wvalid);
      aw_hs += int'(axi_awvalid && axi_awready);
      b_hs  += int'(axi_bvalid && axi_bready);
      dn    += int'(done);
      if (axi_wvalid && (axi_wstrb != 4'h3 || axi_bready)) bad++;
    end
    slave_idle();
    chk("w2_awvalid_cycles", aw_hi, 1);
    chk("w2_aw_handshakes", aw_hs, 1);
    chk("w2_wvalid_cycles", w_hi, 4);
    chk("w2_b_handshakes", b_hs, 1);
    chk("w2_done_count", dn, 1);
    chk("w2_stable_no_early_b", bad, 0);
    chk("w2_response", response, 2'b10);

    // Read with AR delayed one cycle and R after two wait cycles
    @(negedge clk);
    valid = 1; write = 0; address = 34'h200;
    ar_hi = 0; dn = 0; done_c = 0; ara = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      valid = 0;
      axi_arready = (c == 2); axi_rvalid = (c == 5);
      axi_rdata = (c == 5) ? 32'h12345678 : 32'hFFFFFFFF; axi_rresp = 2'b00;
      if (c == 1) ara = axi_araddr;
      ar_hi += int'(axi_arvalid);
      if (done) begin
        dn++;
        done_c = c;
      end
    end
    slave_idle();
    chk("r1_araddr", ara, 34'h200);
    chk("r1_arvalid_cycles", ar_hi, 2);
    chk("r1_done_count", dn, 1);
    chk("r1_done_cycle", done_c, 6);
    chk("r1_read_data", read_data, 32'h12345678);
    chk("r1_response", response, 2'b00);

    // DECERR read, then OKAY write must not disturb read_data
    xact(1'b0, 34'h210, 32'hCAFEF00D, 2'b11, dcyc, dcnt, ars, ara);
    chk("r2_done_cycle", dcyc, 3);
    chk("r2_done_count", dcnt, 1);
    chk("r2_response", response, 2'b11);
    chk("r2_read_data", read_data, 32'hCAFEF00D);
    xact(1'b1, 34'h300, 32'h11112222, 2'b00, dcyc, dcnt, ars, ara);
    chk("w3_done_cycle", dcyc, 3);
    chk("w3_response", response, 2'b00);
    chk("w3_read_data_kept", read_data, 32'hCAFEF00D);

    // Reset asserted while waiting in WRITE_RESP
    @(negedge clk);
    valid = 1; write = 1; address = 34'h400; write_data = 32'h55AA55AA; write_byteenable = 4'hF;
    axi_awready = 1; axi_wready = 1;
    @(negedge clk);
    valid = 0;
    chk("rst_mid_awvalid", axi_awvalid, 1);
    @(negedge clk);
    chk("rst_mid_bready", axi_bready, 1);
    rst_n = 0;
    @(negedge clk);
    chk("rst_mid_awvalid_0", axi_awvalid, 0);
    chk("rst_mid_wvalid_0", axi_wvalid, 0);
    chk("rst_mid_bready_0", axi_bready, 0);
    chk("rst_mid_rready_0", axi_rready, 0);
    chk("rst_mid_done_0", done, 0);
    chk("rst_mid_ready_0", ready, 0);
    chk("rst_mid_read_data", read_data, 0);
    rst_n = 1;
    slave_idle();
    #1 chk("rst_mid_ready_rel", ready, 1);
    @(negedge clk);
    chk("rst_mid_bready_after", axi_bready, 0);
    chk("rst_mid_done_after", done, 0);

    // Misaligned read
    xact(1'b0, 34'h102, 32'h0BADF00D, 2'b00, dcyc, dcnt, ars, ara);
`ifdef SIMPLE2AXI_ALIGN_CHECK_EN
    chk("mis_no_arvalid", ars, 0);
    chk("mis_done_cycle", dcyc, 1);
    chk("mis_done_count", dcnt, 1);
    chk("mis_response", response, 2'b10);
    chk("mis_read_data_kept", read_data, 0);
`else
    chk("mis_arvalid", ars, 1);
    chk("mis_araddr", ara, 34'h102);
    chk("mis_done_cycle", dcyc, 3);
    chk("mis_response", response, 2'b00);
    chk("mis_read_data", read_data, 32'h0BADF00D);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
